mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree for W-bit data. It is the successor to the fixed 8:1 single-bit 2:1-mux tree. The block registers one tree level per cycle and moves data under a valid/ready handshake. It also adds a scan mode in which an internal counter sweeps the select. It sits between a bank of parallel producers and a single serial consumer.

## Interface
- W, default 8: data width per input channel.
- N, default 8: number of input channels; power of two, N ≥ 2.
- L (localparam) = $clog2(N): number of tree levels; also the select width and the pipeline depth.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_sel  input  L  channel select; used when mode=0.
- mode  input  1  0 = external select (in_sel), 1 = scan (internal counter).
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  W  selected channel data.
- out_sel  output  L  select value that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  consumer accepts the output beat.

## Operation
- Tree structure: level k (k = 0..L-1) is a row of 2:1 muxes controlled by select bit k. The LSB is used at the first level. At level k, pair (2j, 2j+1) → node j, and sel bit k = 1 picks the odd input.
- Registers: each level has a W-bit data register for every node in that level, a valid bit, and a copy of the full L-bit select. The select copy travels with the data so that later levels and out_sel use the beat's own select.
- Global advance: adv = out_ready | ~out_valid.
  - When adv = 1, every stage loads from its predecessor.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
- Handshake:
  - in_ready = adv, combinational; it has no dependence on in_valid.
  - A beat is accepted when in_valid & in_ready.
  - If adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Effective select: eff_sel = mode ? scan_cnt : in_sel, sampled on the accepting cycle.
- Scan counter (L bits):
  - Increments by 1 on each accepted beat while mode = 1, wrapping from N-1 to 0.
  - Holds its value while mode = 0.
  - Holds on cycles with no acceptance.
- Mode change: takes effect on the next accepted beat; beats already in the tree are unaffected.
- out_data, out_sel and out_valid are the final-level registers (registered outputs).
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_sel hold stable.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, all internal valid bits = 0, all data registers = 0, scan_cnt = 0.
- in_ready after reset is 1, because out_valid = 0.
- Reset mid-operation: all in-flight beats are discarded on the reset edge. A beat presented in the same cycle as rst = 1 is not accepted, and scan_cnt does not increment.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+L−1. Equivalently, it becomes visible L cycles after the in_valid cycle when there are no stalls.
- Throughput: 1 beat per cycle with out_ready held high.
- Stall: with out_valid = 1 and out_ready = 0, in_ready = 0 in the same cycle and the pipeline freezes. Releasing out_ready resumes on the next edge with no loss and no duplication.
- Simultaneous output consume and input accept in one cycle is legal: both happen.
- N = 2: L = 1, a single registered stage with 1-cycle latency.

## Test plan
- Reset/idle: assert rst for 2 cycles, then hold in_valid = 0 → out_valid = 0, out_data = 0, out_sel = 0, in_ready = 1 throughout.
- External select sweep (W=8, N=8, channel c = 8'hA0+c, out_ready = 1, mode = 0): in_sel = 0..7 on consecutive cycles → after 3 cycles, out_data = A0..A7 on consecutive cycles, with out_sel matching.
- Scan mode with wrap: mode = 1, 10 consecutive beats → out_sel = 0,1,…,7,0,1. Then mode = 0 for 2 beats followed by mode = 1 → the next scan beat has out_sel = 2.
- Backpressure: stream 6 beats and drop out_ready for 4 cycles while out_valid = 1 → in_ready = 0 for those 4 cycles, out_data is stable, and all 6 beats arrive in order exactly once.
- Bubbles: in_valid pattern 1,0,1,1,0 → out_valid pattern 1,0,1,1,0, delayed by L.
- Mid-stream reset: 3 beats in flight, then rst for 1 cycle → out_valid = 0 next cycle, none of the 3 beats emerge, and scan_cnt = 0.

Source files
------------

// File: rtl/mux_tree_if.sv
// Handshake bundle between the parallel producers, the mux tree and the serial consumer.
// master drives the channel data and output-side ready; slave is the mux tree itself.
interface mux_tree_if #(
    parameter int W = 8,
    parameter int N = 8
);
    localparam int L = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [L-1:0]   in_sel;
    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic [L-1:0]   out_sel;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_sel, mode, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_sel, mode, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one registered level per cycle, valid/ready flow control
// with a global advance, plus a scan mode where an internal counter drives the select.
module mux_tree_pipe #(
    parameter int W = 8,
    parameter int N = 8
) (
    input logic       clk,
    input logic       rst,
    mux_tree_if.slave bus
);
    localparam int L     = $clog2(N);
    localparam int NODES = N - 1;

    // All tree levels packed back to back: level k starts at node N - (N >> k).
    logic [NODES*W-1:0] tree_r;
    logic [NODES*W-1:0] tree_nxt_s;
    logic [L-1:0]       sel_r [L];
    logic [L-1:0]       valid_r;
    logic [L-1:0]       valid_nxt_s;
    logic [L-1:0]       scan_cnt_r;
    logic [L-1:0]       eff_sel_s;
    logic               adv_s;
    logic               accept_s;

    assign adv_s    = bus.out_ready | ~valid_r[L-1];
    assign accept_s = bus.in_valid & adv_s;

    // Select source for the beat entering stage 0.
    always_comb begin
        eff_sel_s = bus.in_sel;
        if (bus.mode) begin
            eff_sel_s = scan_cnt_r;
        end else begin
            eff_sel_s = bus.in_sel;
        end
    end

    generate
        for (genvar k = 0; k < L; k++) begin : g_lvl
            localparam int DST = N - (N >> k);
            localparam int CNT = N >> (k + 1);
            for (genvar j = 0; j < CNT; j++) begin : g_node
                if (k == 0) begin : g_first
                    assign tree_nxt_s[(DST+j)*W +: W] = eff_sel_s[0]
                        ? bus.in_data[(2*j+1)*W +: W]
                        : bus.in_data[(2*j)*W +: W];
                end else begin : g_inner
                    localparam int SRC = N - (N >> (k - 1));
                    // Each level steers with its own beat's select copy, not the live input.
                    assign tree_nxt_s[(DST+j)*W +: W] = sel_r[k-1][k]
                        ? tree_r[(SRC+2*j+1)*W +: W]
                        : tree_r[(SRC+2*j)*W +: W];
                end
            end
        end

        if (L == 1) begin : g_valid_one
            assign valid_nxt_s = accept_s;
        end else begin : g_valid_many
            assign valid_nxt_s = {valid_r[L-2:0], accept_s};
        end
    endgenerate

    // Pipeline registers: whole tree shifts together on advance, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            tree_r  <= '0;
            valid_r <= '0;
            for (int k = 0; k < L; k++) begin
                sel_r[k] <= '0;
            end
        end else if (adv_s) begin
            tree_r   <= tree_nxt_s;
            valid_r  <= valid_nxt_s;
            sel_r[0] <= eff_sel_s;
            for (int k = 1; k < L; k++) begin
                sel_r[k] <= sel_r[k-1];
            end
        end
    end

    // Scan counter advances only on accepted beats taken in scan mode; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
        end else if (accept_s && bus.mode) begin
            scan_cnt_r <= scan_cnt_r + L'(1'b1);
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_data  = tree_r[(N-2)*W +: W];
    assign bus.out_sel   = sel_r[L-1];
    assign bus.out_valid = valid_r[L-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe (W=8, N=8): channel c carries 8'hA0+c, so the
// expected out_data is always 8'hA0 + out_sel of the beat.
module tb_mux_tree_pipe;
    localparam int W = 8;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_tree_if #(.W(W), .N(N)) bus ();

    mux_tree_pipe #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_window();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            rst = (w < 2);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid w%0d: got %0b expected 0", w, bus.out_valid);
            end
            checks++;
            if (bus.out_data !== 8'h00) begin
                errors++; $display("FAIL reset_data w%0d: got %0h expected 00", w, bus.out_data);
            end
            checks++;
            if (bus.out_sel !== 3'd0) begin
                errors++; $display("FAIL reset_sel w%0d: got %0d expected 0", w, bus.out_sel);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_ready w%0d: got %0b expected 1", w, bus.in_ready);
            end
            next_window();
        end
    endtask

    task automatic test_sweep();
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 12; w++) begin
            bus.in_valid = (w < 8);
            bus.in_sel   = 3'(w);
            #1;
            if (w >= 3 && w < 11) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'hA0 + w - 3)
                    || bus.out_sel !== 3'(w - 3)) begin
                    errors++;
                    $display("FAIL sweep w%0d: got v=%0b d=%0h s=%0d expected v=1 d=%0h s=%0d",
                             w, bus.out_valid, bus.out_data, bus.out_sel, 8'(8'hA0 + w - 3), w - 3);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++; $display("FAIL sweep_idle w%0d: got %0b expected 0", w, bus.out_valid);
                end
            end
            next_window();
        end
    endtask

    task automatic test_scan();
        logic [2:0] es;
        int         i;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 16; w++) begin
            bus.in_valid = (w <= 12);
            bus.mode     = !(w == 10 || w == 11);
            bus.in_sel   = (w == 10) ? 3'd6 : (w == 11) ? 3'd7 : 3'd5;
            #1;
            i = w - 3;
            if (i >= 0 && i <= 12) begin
                if (i < 10)       es = 3'(i % 8);
                else if (i == 10) es = 3'd6;
                else if (i == 11) es = 3'd7;
                else              es = 3'd2;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sel !== es
                    || bus.out_data !== 8'(8'hA0 + es)) begin
                    errors++;
                    $display("FAIL scan beat%0d: got v=%0b s=%0d d=%0h expected v=1 s=%0d d=%0h",
                             i, bus.out_valid, bus.out_sel, bus.out_data, es, 8'(8'hA0 + es));
                end
            end
            next_window();
        end
    endtask

    task automatic test_backpressure();
        int         k;
        logic       rdy;
        logic [7:0] got[$];
        k        = 0;
        bus.mode = 1'b0;
        for (int w = 0; w < 16; w++) begin
            bus.in_valid  = (k < 6);
            bus.in_sel    = 3'(k);
            bus.out_ready = !(w >= 5 && w <= 8);
            #1;
            rdy = bus.in_ready;
            checks++;
            if (rdy !== !(w >= 5 && w <= 8)) begin
                errors++; $display("FAIL bp_ready w%0d: got %0b expected %0b", w, rdy, !(w >= 5 && w <= 8));
            end
            if (w >= 5 && w <= 8) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA2) begin
                    errors++;
                    $display("FAIL bp_hold w%0d: got v=%0b d=%0h expected v=1 d=a2", w, bus.out_valid, bus.out_data);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
            @(posedge clk);
            if (bus.in_valid && rdy) k++;
            #1;
        end
        checks++;
        if (got.size() !== 6) begin
            errors++; $display("FAIL bp_count: got %0d expected 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++;
            if (got[i] !== 8'(8'hA0 + i)) begin
                errors++; $display("FAIL bp_order beat%0d: got %0h expected %0h", i, got[i], 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_bubbles();
        bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit ev;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            bus.in_valid = (w < 5) ? pat[w] : 1'b0;
            bus.in_sel   = 3'(w);
            #1;
            ev = (w >= 3) ? pat[w-3] : 1'b0;
            checks++;
            if (bus.out_valid !== ev) begin
                errors++; $display("FAIL bubble_valid w%0d: got %0b expected %0b", w, bus.out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (bus.out_data !== 8'(8'hA0 + w - 3)) begin
                    errors++; $display("FAIL bubble_data w%0d: got %0h expected %0h", w, bus.out_data, 8'(8'hA0 + w - 3));
                end
            end
            next_window();
        end
    endtask

    task automatic test_mid_reset();
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_sel    = 3'd0;
        for (int w = 0; w < 13; w++) begin
            rst          = (w == 3);
            bus.in_valid = (w <= 3) || (w == 9);
            #1;
            if (w == 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd3) begin
                    errors++; $display("FAIL mr_pre: got v=%0b s=%0d expected v=1 s=3", bus.out_valid, bus.out_sel);
                end
            end
            if (w == 4) begin
                checks++;
                if (bus.out_data !== 8'h00 || bus.out_sel !== 3'd0 || bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mr_clear: got d=%0h s=%0d r=%0b expected d=00 s=0 r=1", bus.out_data, bus.out_sel, bus.in_ready);
                end
            end
            if (w >= 4 && w <= 11) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++; $display("FAIL mr_flush w%0d: got %0b expected 0", w, bus.out_valid);
                end
            end
            if (w == 12) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd0 || bus.out_data !== 8'hA0) begin
                    errors++;
                    $display("FAIL mr_scan: got v=%0b s=%0d d=%0h expected v=1 s=0 d=a0", bus.out_valid, bus.out_sel, bus.out_data);
                end
            end
            next_window();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            bus.in_data[c*W +: W] = 8'(8'hA0 + c);
        end
        next_window();
        test_reset();
        test_sweep();
        test_scan();
        test_backpressure();
        test_bubbles();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
